// File: rtl/user_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : user_input_pkg
//  Purpose  : Shared constants for the user input conditioner: repeat FSM
//             state encoding and default parameter values.
//  Revision : 1.0  initial release
// ============================================================================
package user_input_pkg;

    // Repeat FSM state encoding
    localparam logic [1:0] c_LOW    = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_REPEAT = 2'd2;

    // Default parameter values
    localparam int c_DEF_SYNC_STAGES     = 2;
    localparam int c_DEF_DEBOUNCE_CYCLES = 3;
    localparam int c_DEF_REPEAT_DELAY    = 8;
    localparam int c_DEF_REPEAT_PERIOD   = 4;
    localparam int c_DEF_CNT_W           = 8;

endpackage
`default_nettype wire

// File: rtl/input_sync.sv
`default_nettype none
// ============================================================================
//  Module   : input_sync
//  Purpose  : SYNC_STAGES-deep flop chain bringing an asynchronous input into
//             the clk domain. Chain resets to 0.
//  Revision : 1.0  initial release
// ============================================================================
module input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw input through the synchronizer chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/user_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : user_input_conditioner
//  Purpose  : Synchronizes and debounces a raw user input, producing a clean
//             level, single-cycle rise/fall pulses, a held flag and
//             auto-repeat strobes while the input stays asserted.
//  Revision : 1.0  initial release
// ============================================================================
module user_input_conditioner
    import user_input_pkg::*;
#(
    parameter int SYNC_STAGES     = c_DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = c_DEF_REPEAT_PERIOD,
    parameter int CNT_W           = c_DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic held,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] c_DEB    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] c_PERIOD = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    logic             w_s;
    logic [CNT_W-1:0] r_deb_cnt, w_deb_cnt_nxt, w_deb_inc;
    logic             r_level, w_toggle, w_rise_evt, w_fall_evt;
    logic             r_rise, r_fall;
    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt, w_hold_inc;
    logic [CNT_W-1:0] r_rep_cnt, w_rep_cnt_nxt, w_rep_inc;
    logic             r_held, w_held_nxt;
    logic             r_repeat, w_repeat_nxt;

    input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_input_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (w_s)
    );

    // Saturating increments so no counter can ever wrap
    assign w_deb_inc  = (r_deb_cnt  == '1) ? r_deb_cnt  : r_deb_cnt  + c_ONE;
    assign w_hold_inc = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + c_ONE;
    assign w_rep_inc  = (r_rep_cnt  == '1) ? r_rep_cnt  : r_rep_cnt  + c_ONE;

    // Debounce: count consecutive disagreeing samples, flip level when full
    always_comb begin
        w_deb_cnt_nxt = '0;
        w_toggle      = 1'b0;
        if (w_s != r_level) begin
            if (w_deb_inc >= c_DEB) begin
                w_toggle = 1'b1;
            end else begin
                w_deb_cnt_nxt = w_deb_inc;
            end
        end
    end

    assign w_rise_evt = w_toggle & ~r_level;
    assign w_fall_evt = w_toggle &  r_level;

    // Debounced level and edge pulses, registered together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_deb_cnt <= '0;
            r_level   <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_deb_cnt <= w_deb_cnt_nxt;
            r_level   <= r_level ^ w_toggle;
            r_rise    <= w_rise_evt;
            r_fall    <= w_fall_evt;
        end
    end

    // Repeat FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Repeat FSM next-state logic; a release always wins
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_LOW: begin
                if (w_rise_evt) w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                if (w_fall_evt)                w_state_nxt = c_LOW;
                else if (w_hold_inc >= c_DELAY) w_state_nxt = c_REPEAT;
            end
            c_REPEAT: begin
                if (w_fall_evt) w_state_nxt = c_LOW;
            end
            default: w_state_nxt = c_LOW;
        endcase
    end

    // Repeat FSM outputs: next values of counters, held and repeat strobe
    always_comb begin
        w_hold_cnt_nxt = '0;
        w_rep_cnt_nxt  = '0;
        w_held_nxt     = 1'b0;
        w_repeat_nxt   = 1'b0;
        case (r_state)
            c_WAIT: begin
                if (!w_fall_evt) begin
                    w_hold_cnt_nxt = w_hold_inc;
                    if (w_hold_inc >= c_DELAY) begin
                        w_held_nxt   = 1'b1;
                        w_repeat_nxt = 1'b1;
                    end
                end
            end
            c_REPEAT: begin
                if (!w_fall_evt) begin
                    w_hold_cnt_nxt = r_hold_cnt;
                    w_held_nxt     = 1'b1;
                    if (w_rep_inc >= c_PERIOD) begin
                        w_repeat_nxt = 1'b1;
                    end else begin
                        w_rep_cnt_nxt = w_rep_inc;
                    end
                end
            end
            default: begin
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    // Register hold/repeat counters and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_held     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
            r_rep_cnt  <= w_rep_cnt_nxt;
            r_held     <= w_held_nxt;
            r_repeat   <= w_repeat_nxt;
        end
    end

    assign level_out    = r_level;
    assign rise_pulse   = r_rise;
    assign fall_pulse   = r_fall;
    assign held         = r_held;
    assign repeat_pulse = r_repeat;

endmodule
`default_nettype wire
